phy_rx_unstriper: RTL
=====================

# phy_rx_unstriper

Receive-side counterpart of the two-lane PHY transmitter. It samples two 8-bit byte lanes with per-lane valids, detects link-up from an idle-symbol training sequence, and reassembles each pair of byte-pair beats into one 32-bit word. It sits between the lane inputs and the 32-bit receive data path, and flags framing errors.

## Interface
Parameters:
- IDLE_SYM, 8'hBC: idle/training symbol driven on both lanes while their valids are low.
- BC_COUNT, 4: consecutive idle cycles required to declare the link active (range 1..15).

Ports:
- clk_2f  input  1  single clock, byte rate; all logic on its rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- data_in_0  input  8  lane 0 byte.
- data_in_1  input  8  lane 1 byte.
- valid_in0  input  1  lane 0 byte valid.
- valid_in1  input  1  lane 1 byte valid.
- data_out  output  32  reassembled word; holds its last value when valid_out=0.
- valid_out  output  1  one-cycle strobe per word.
- active  output  1  link trained and accepting data.
- error  output  1  one-cycle pulse on a framing error.

## Operation
- Striping: word bytes B3=[31:24], B2=[23:16], B1=[15:8], B0=[7:0].
  - First beat: lane0=B3, lane1=B2.
  - Second beat: lane0=B1, lane1=B0.
- Reset value of every output is 0. Internal state after reset: SEARCH, idle counter=0, phase=0, holding register=0.
- Idle cycle: valid_in0=valid_in1=0 and data_in_0=data_in_1=IDLE_SYM.
- SEARCH state (active=0):
  - Each idle cycle increments the counter, saturating at BC_COUNT.
  - Any non-idle cycle, including valid data, clears the counter. Such data is discarded, and no error is raised.
  - When the counter reaches BC_COUNT, go to ACTIVE.
- ACTIVE state (active=1):
  - Both valids=1, phase=0: store B3,B2 in the holding register; phase<=1.
  - Both valids=1, phase=1: data_out<={held B3,B2,B1,B0}; valid_out<=1; phase<=0.
  - Valids differ: error<=1, drop any partial word, phase<=0, stay ACTIVE.
  - Idle cycle with phase=1: error<=1, drop the partial word, phase<=0.
  - Both valids=0 and either lane is not IDLE_SYM: error<=1, phase<=0, counter<=0, go to SEARCH (active falls).
- error and valid_out never assert in the same cycle: a completed word always has both valids high.
- No backpressure; every completed word must be consumed in its strobe cycle.

## Timing
- Word latency: beats presented in cycles n and n+1 produce data_out/valid_out in cycle n+2 (registered output).
- Link-up: idle cycles n..n+BC_COUNT-1 raise active in cycle n+BC_COUNT. The first accepted beat is the first cycle in which active is already 1.
- error is registered: a fault presented in cycle n pulses error in cycle n+1.
- Loss of sync: the fault cycle n causes active=0 from cycle n+1.
- Back-to-back words are allowed: one word every 2 cycles, with no idle cycle required between words.
- Reset asserted mid-word (low at any time) immediately drives outputs to 0 and discards the held bytes. Training restarts from counter 0 after release.

## Test plan
- Reset, then 4 idle cycles (IDLE_SYM on both lanes) -> active=1 in cycle 4; valid_out=0 and error=0 throughout.
- After link-up, send beats (AA,BB) then (CC,DD) -> data_out=32'hAABBCCDD with valid_out=1 two cycles after the first beat. Continue with back-to-back words 12345678 and 9ABCDEF0 -> one strobe every 2 cycles.
- Send only 3 idle cycles, then a data beat, then 4 idle cycles -> active stays 0 until the 4th idle after the beat; the beat is dropped silently.
- While active, send beat (11,22), then an idle cycle -> error pulses once; no valid_out; the next full word (33,44),(55,66) yields 32'h33445566.
- While active, set valid_in0=1 and valid_in1=0 -> error pulses once, active stays 1. Then send idle with data_in_0=8'h00 -> error pulses and active drops the next cycle.
- Assert reset between the two beats of a word -> all outputs 0 at once. After release and 4 idle cycles, a new word is reassembled correctly with no stale bytes.

Source files
------------

// File: rtl/phy_rx_unstriper_if.sv
// Lane-side and word-side signals of the two-lane receive unstriper.
// The master drives the lanes; the slave (the unstriper) drives the word outputs.
interface phy_rx_unstriper_if;
  logic [7:0]  data_in_0;
  logic [7:0]  data_in_1;
  logic        valid_in0;
  logic        valid_in1;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active;
  logic        error;

  modport master (
    output data_in_0, data_in_1, valid_in0, valid_in1,
    input  data_out, valid_out, active, error
  );

  modport slave (
    input  data_in_0, data_in_1, valid_in0, valid_in1,
    output data_out, valid_out, active, error
  );
endinterface

// File: rtl/phy_rx_unstriper.sv
// Two-lane receive unstriper: trains on idle symbols, then joins pairs of
// byte-pair beats into 32-bit words and flags framing errors.
module phy_rx_unstriper #(
  parameter logic [7:0]  IDLE_SYM = 8'hBC,
  parameter int unsigned BC_COUNT = 4
) (
  input  logic               clk_2f,
  input  logic               reset,
  phy_rx_unstriper_if.slave  lanes
);

  localparam logic [3:0] BC_LIMIT = 4'(BC_COUNT);

  typedef enum logic {
    SEARCH = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        phase_q, phase_d;
  logic [15:0] hold_q, hold_d;
  logic [31:0] data_out_q, data_out_d;
  logic        valid_out_q, valid_out_d;
  logic        error_q, error_d;
  logic        is_idle;
  logic        both_valid;
  logic        valid_split;

  assign is_idle = !lanes.valid_in0 && !lanes.valid_in1 &&
                   (lanes.data_in_0 == IDLE_SYM) && (lanes.data_in_1 == IDLE_SYM);
  assign both_valid  = lanes.valid_in0 && lanes.valid_in1;
  assign valid_split = lanes.valid_in0 != lanes.valid_in1;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    phase_d     = phase_q;
    hold_d      = hold_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    error_d     = 1'b0;

    unique case (state_q)
      SEARCH: begin
        phase_d = 1'b0;
        // Any non-idle cycle, data included, restarts training silently.
        if (is_idle) begin
          if (count_q < BC_LIMIT) count_d = count_q + 4'd1;
        end else begin
          count_d = 4'd0;
        end
        if (count_d == BC_LIMIT) state_d = ACTIVE;
      end

      ACTIVE: begin
        if (both_valid) begin
          if (!phase_q) begin
            hold_d  = {lanes.data_in_0, lanes.data_in_1};
            phase_d = 1'b1;
          end else begin
            data_out_d  = {hold_q, lanes.data_in_0, lanes.data_in_1};
            valid_out_d = 1'b1;
            phase_d     = 1'b0;
          end
        end else if (valid_split) begin
          error_d = 1'b1;
          phase_d = 1'b0;
        end else if (is_idle) begin
          error_d = phase_q;
          phase_d = 1'b0;
        end else begin
          // Garbage on idle lanes means alignment is lost: retrain.
          error_d = 1'b1;
          phase_d = 1'b0;
          count_d = 4'd0;
          state_d = SEARCH;
        end
      end

      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state_q     <= SEARCH;
      count_q     <= 4'd0;
      phase_q     <= 1'b0;
      hold_q      <= 16'd0;
      data_out_q  <= 32'd0;
      valid_out_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      error_q     <= error_d;
    end
  end

  assign lanes.data_out  = data_out_q;
  assign lanes.valid_out = valid_out_q;
  assign lanes.active    = (state_q == ACTIVE);
  assign lanes.error     = error_q;

endmodule
